// File: rtl/seqgen_pkg.sv
// seqgen_pkg
// Shared definitions for the LED sequence generator and the game engine that
// consumes its output: FSM state encoding, GRB field layout and the default
// colour constants (the engine also reuses OFF_GRB as its own "off" value).
// No ports; imported with "import seqgen_pkg::*".
package seqgen_pkg;

  // Animation state of the pattern source.
  typedef enum logic [1:0] {
    SWEEP_UP   = 2'b00,
    SWEEP_DOWN = 2'b01,
    WIN        = 2'b10
  } seqgen_state_e;

  // One LED occupies 24 bits, laid out G[23:16] R[15:8] B[7:0].
  localparam int LED_W     = 24;
  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  // Assemble a GRB word from its three 8-bit channels.
  function automatic logic [LED_W-1:0] grb_pack(input logic [7:0] g,
                                                input logic [7:0] r,
                                                input logic [7:0] b);
    logic [LED_W-1:0] w;
    w = 24'h00_00_00;
    w[GRB_G_LSB +: 8] = g;
    w[GRB_R_LSB +: 8] = r;
    w[GRB_B_LSB +: 8] = b;
    return w;
  endfunction

  localparam logic [LED_W-1:0] OFF_GRB        = 24'h00_00_00;
  localparam logic [LED_W-1:0] MOVE_GRB_DEF   = grb_pack(8'h00, 8'h40, 8'h00);
  localparam logic [LED_W-1:0] TARGET_GRB_DEF = grb_pack(8'h08, 8'h00, 8'h00);
  localparam logic [LED_W-1:0] HIT_GRB_DEF    = grb_pack(8'h40, 8'h40, 8'h40);
  localparam logic [LED_W-1:0] WIN_GRB_DEF    = grb_pack(8'h40, 8'h00, 8'h00);

endpackage

// File: rtl/seqgen_step_timer.sv
// seqgen_step_timer
// Free-running step timer. Counts enabled clocks and raises step on the clock
// whose edge will wrap the count, i.e. when tmr >= period-1. Comparing with >=
// (not ==) means a period that shrinks mid-count steps immediately instead of
// waiting for the counter to wrap around.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high; clears the count
//   en     - count enable; count holds while low
//   period - clocks per step, must be >= 1
//   clr    - synchronous clear, suppresses step
//   step   - high in the cycle whose clock edge completes a period
module seqgen_step_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             clr,
  output logic             step
);

  logic [CNT_W-1:0] tmr_r;
  logic             step_s;

  // Step request: enabled, not being cleared, and the period is used up.
  always_comb begin
    step_s = 1'b0;
    if (en && !clr) begin
      step_s = (tmr_r >= (period - CNT_W'(1)));
    end else begin
      step_s = 1'b0;
    end
  end

  // Count register: clear on reset/clr/step, otherwise advance when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_r <= '0;
    end else if (clr || step_s) begin
      tmr_r <= '0;
    end else if (en) begin
      tmr_r <= tmr_r + CNT_W'(1);
    end else begin
      tmr_r <= tmr_r;
    end
  end

  assign step = step_s;

endmodule

// File: rtl/led_sequence_gen.sv
// led_sequence_gen
// Pattern source for the game engine: one lit pixel bounces across a GRB LED
// strip at a speed set by the engine level; once the win level is reached all
// LEDs blink green instead.
// Build option: define SEQGEN_WRAP_EN to make the pixel wrap from the last LED
// back to LED0 instead of bouncing (SWEEP_DOWN is then never entered).
// Ports:
//   clk     - clock
//   reset   - synchronous, active-high
//   run     - advance enable (engine Run)
//   lvl     - current level (engine Lvl)
//   grb_out - LED i at [24i+23:24i], LED0 in the LSBs, G/R/B per byte
//   flag    - moving pixel sits on TARGET_POS
//   cycle   - one-clock pulse in the first cycle a new pattern is visible
module led_sequence_gen
  import seqgen_pkg::*;
#(
  parameter int               NUM_LEDS    = 5,
  parameter int               TARGET_POS  = 2,
  parameter int               BASE_PERIOD = 2**24,
  parameter int               CNT_W       = 26,
  parameter int               WIN_LVL     = 5,
  parameter logic [LED_W-1:0] MOVE_GRB    = MOVE_GRB_DEF,
  parameter logic [LED_W-1:0] TARGET_GRB  = TARGET_GRB_DEF,
  parameter logic [LED_W-1:0] HIT_GRB     = HIT_GRB_DEF,
  parameter logic [LED_W-1:0] WIN_GRB     = WIN_GRB_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [2:0]                lvl,
  output logic [LED_W*NUM_LEDS-1:0] grb_out,
  output logic                      flag,
  output logic                      cycle
);

  localparam logic [1:0] ST_UP   = SWEEP_UP;
  localparam logic [1:0] ST_DOWN = SWEEP_DOWN;
  localparam logic [1:0] ST_WIN  = WIN;

  localparam logic [2:0]       LAST_POS  = 3'(NUM_LEDS - 1);
  localparam logic [2:0]       TGT_POS   = 3'(TARGET_POS);
  localparam logic [2:0]       WIN_LVL_C = 3'(WIN_LVL);
  localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_PERIOD);
  // Win blink runs at a fixed quarter of the base period, never below 1.
  localparam logic [CNT_W-1:0] WIN_PER_C =
    CNT_W'(((BASE_PERIOD >> 2) > 0) ? (BASE_PERIOD >> 2) : 1);

  logic [1:0]                st_r;
  logic [2:0]                pos_r;
  logic                      blink_r;
  logic                      cycle_r;

  logic                      win_req_s;
  logic [CNT_W-1:0]          shifted_s;
  logic [CNT_W-1:0]          period_s;
  logic                      timer_en_s;
  logic                      timer_clr_s;
  logic                      step_s;
  logic [LED_W*NUM_LEDS-1:0] grb_s;
  logic                      flag_s;

  assign win_req_s = (lvl >= WIN_LVL_C);

  // Step period for the current state and level, clamped to at least 1.
  always_comb begin
    shifted_s = BASE_C >> lvl;
    period_s  = CNT_W'(1);
    if (st_r == ST_WIN) begin
      period_s = WIN_PER_C;
    end else if (shifted_s == '0) begin
      period_s = CNT_W'(1);
    end else begin
      period_s = shifted_s;
    end
  end

  // Timer control: WIN ignores run; entering or leaving WIN restarts the period.
  always_comb begin
    timer_en_s  = 1'b0;
    timer_clr_s = 1'b0;
    if (st_r == ST_WIN) begin
      timer_en_s  = 1'b1;
      timer_clr_s = !win_req_s;
    end else begin
      timer_en_s  = run;
      timer_clr_s = win_req_s;
    end
  end

  seqgen_step_timer #(
    .CNT_W (CNT_W)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en_s),
    .period (period_s),
    .clr    (timer_clr_s),
    .step   (step_s)
  );

  // Animation FSM: win entry/exit outrank steps; cycle marks a new pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r    <= ST_UP;
      pos_r   <= 3'd0;
      blink_r <= 1'b0;
      cycle_r <= 1'b0;
    end else if ((st_r != ST_WIN) && win_req_s) begin
      st_r    <= ST_WIN;
      blink_r <= 1'b1;
      cycle_r <= 1'b1;
    end else if ((st_r == ST_WIN) && !win_req_s) begin
      st_r    <= ST_UP;
      pos_r   <= 3'd0;
      blink_r <= 1'b0;
      cycle_r <= 1'b0;
    end else if (step_s) begin
      cycle_r <= 1'b1;
      case (st_r)
        ST_UP: begin
          if (pos_r == LAST_POS) begin
`ifdef SEQGEN_WRAP_EN
            pos_r <= 3'd0;
`else
            pos_r <= LAST_POS - 3'd1;
            st_r  <= ST_DOWN;
`endif
          end else begin
            pos_r <= pos_r + 3'd1;
          end
        end
        ST_DOWN: begin
          if (pos_r == 3'd0) begin
            pos_r <= 3'd1;
            st_r  <= ST_UP;
          end else begin
            pos_r <= pos_r - 3'd1;
          end
        end
        ST_WIN: begin
          blink_r <= ~blink_r;
        end
        default: begin
          st_r  <= ST_UP;
          pos_r <= 3'd0;
        end
      endcase
    end else begin
      cycle_r <= 1'b0;
    end
  end

  // Pattern decode from registered state only.
  always_comb begin
    grb_s  = '0;
    flag_s = 1'b0;
    if (st_r == ST_WIN) begin
      flag_s = 1'b0;
      if (blink_r) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          grb_s[i*LED_W +: LED_W] = WIN_GRB;
        end
      end else begin
        grb_s = '0;
      end
    end else begin
      flag_s = (pos_r == TGT_POS);
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (3'(i) == pos_r) begin
          // The moving pixel turns white when it lands on the target.
          grb_s[i*LED_W +: LED_W] = (pos_r == TGT_POS) ? HIT_GRB : MOVE_GRB;
        end else if (i == TARGET_POS) begin
          grb_s[i*LED_W +: LED_W] = TARGET_GRB;
        end else begin
          grb_s[i*LED_W +: LED_W] = OFF_GRB;
        end
      end
    end
  end

  assign grb_out = grb_s;
  assign flag    = flag_s;
  assign cycle   = cycle_r;

endmodule

// File: tb/tb_led_sequence_gen.sv
// tb_led_sequence_gen
// Directed bench for led_sequence_gen with BASE_PERIOD=16. Each expected step
// (pattern, flag, clocks since the previous pattern change) is queued when the
// stimulus is applied and compared when the DUT raises cycle.
module tb_led_sequence_gen;

  localparam int GW = 120;
  localparam logic [23:0] C_MOVE = 24'h00_40_00;
  localparam logic [23:0] C_TGT  = 24'h08_00_00;
  localparam logic [23:0] C_HIT  = 24'h40_40_40;
  localparam logic [23:0] C_WIN  = 24'h40_00_00;
`ifdef SEQGEN_WRAP_EN
  localparam int SWEEP_STEPS = 6;
`else
  localparam int SWEEP_STEPS = 9;
`endif

  typedef struct {
    string          tag;
    logic [GW-1:0]  grb;
    logic           flg;
    int             clks;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          run   = 1'b0;
  logic [2:0]    lvl   = 3'd0;
  logic [GW-1:0] grb_out;
  logic          flag;
  logic          cycle;

  int   errors = 0;
  int   checks = 0;
  int   pos_m  = 0;
  bit   down_m = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  led_sequence_gen #(
    .BASE_PERIOD (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .lvl     (lvl),
    .grb_out (grb_out),
    .flag    (flag),
    .cycle   (cycle)
  );

  function automatic logic [GW-1:0] exp_sweep(input int p);
    logic [GW-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == p)      r[i*24 +: 24] = (p == 2) ? C_HIT : C_MOVE;
      else if (i == 2) r[i*24 +: 24] = C_TGT;
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] exp_win(input bit b);
    logic [GW-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (b) r[i*24 +: 24] = C_WIN;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [GW-1:0] obs,
                     input logic [GW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference position sequence: bounce, or wrap when the option is built in.
  task automatic advance_model();
`ifdef SEQGEN_WRAP_EN
    pos_m = (pos_m == 4) ? 0 : pos_m + 1;
`else
    if (!down_m) begin
      if (pos_m == 4) begin pos_m = 3; down_m = 1'b1; end
      else pos_m = pos_m + 1;
    end else begin
      if (pos_m == 0) begin pos_m = 1; down_m = 1'b0; end
      else pos_m = pos_m - 1;
    end
`endif
  endtask

  task automatic expect_step(input string tag, input logic [GW-1:0] g,
                             input logic f, input int clks);
    exp_t e;
    int   n;
    e.tag = tag; e.grb = g; e.flg = f; e.clks = clks;
    sb.push_back(e);
    n = 0;
    do begin
      tick();
      n++;
    end while (cycle !== 1'b1 && n < 200);
    e = sb.pop_front();
    chk({e.tag, "_clks"}, GW'(n), GW'(e.clks));
    chk({e.tag, "_grb"}, grb_out, e.grb);
    chk({e.tag, "_flag"}, GW'(flag), GW'(e.flg));
  endtask

  task automatic step_sweep(input string tag, input int clks);
    advance_model();
    expect_step(tag, exp_sweep(pos_m), (pos_m == 2), clks);
  endtask

  initial begin
    int cyc_seen;

    // Reset state
    reset = 1'b1; run = 1'b0; lvl = 3'd0;
    tick(); tick();
    chk("rst_grb", grb_out, exp_sweep(0));
    chk("rst_flag", GW'(flag), GW'(1'b0));
    chk("rst_cycle", GW'(cycle), GW'(1'b0));
    reset = 1'b0;
    pos_m = 0; down_m = 1'b0;

    // Full traversal at level 0: one step per 16 clocks
    run = 1'b1;
    for (int k = 0; k < SWEEP_STEPS; k++) begin
      step_sweep($sformatf("sweep%0d", k), 16);
    end

    // Level raised with tmr=10 already past the new period: immediate step
    repeat (10) tick();
    lvl = 3'd2;
    step_sweep("lvl_jump", 1);

    // Pause on the target LED with tmr=5, then resume after 11 clocks
    lvl = 3'd0;
    repeat (5) tick();
    run = 1'b0;
    cyc_seen = 0;
    repeat (100) begin
      tick();
      if (cycle === 1'b1) cyc_seen++;
    end
    chk("hold_cycle", GW'(cyc_seen), GW'(0));
    chk("hold_grb", grb_out, exp_sweep(2));
    chk("hold_flag", GW'(flag), GW'(1'b1));
    run = 1'b1;
    step_sweep("resume", 11);

    // Level 2: period 4, including the turn at the far end
    lvl = 3'd2;
    step_sweep("fast0", 4);
    step_sweep("fast1", 4);

    // Win mode mid-sweep, with run low to show it is ignored
    repeat (2) tick();
    run = 1'b0;
    lvl = 3'd5;
    expect_step("win_enter", exp_win(1'b1), 1'b0, 1);
    expect_step("win_off", exp_win(1'b0), 1'b0, 4);
    expect_step("win_on", exp_win(1'b1), 1'b0, 4);
    expect_step("win_off2", exp_win(1'b0), 1'b0, 4);

    // Leaving win: back to LED0 with a fresh period
    lvl = 3'd0;
    tick();
    chk("exit_grb", grb_out, exp_sweep(0));
    chk("exit_cycle", GW'(cycle), GW'(1'b0));
    pos_m = 0; down_m = 1'b0;
    run = 1'b1;
    step_sweep("after_win", 16);

    // Reset while in win mode
    lvl = 3'd5;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_win_grb", grb_out, exp_sweep(0));
    chk("rst_win_flag", GW'(flag), GW'(1'b0));
    chk("rst_win_cycle", GW'(cycle), GW'(1'b0));
    lvl = 3'd0;
    reset = 1'b0;

    // Reset coinciding with a step edge (tmr=15)
    repeat (15) tick();
    reset = 1'b1;
    tick();
    chk("rst_step_grb", grb_out, exp_sweep(0));
    chk("rst_step_cycle", GW'(cycle), GW'(1'b0));
    reset = 1'b0;
    pos_m = 0; down_m = 1'b0;
    step_sweep("post_reset", 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
